// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the programmable synchronous FIFO.
//   wide_ptr_t  : container wide enough for any pointer/level of any instance
//   fifo_depth  : number of entries for a given address width
//   fifo_level  : occupancy from a write/read pointer pair (modulo 2**ptr_width)
// Per-instance ptr_t/level_t typedefs are derived inside the modules from their
// own ADDR_WIDTH, since package items cannot follow a module parameter.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned MAX_PTR_WIDTH = 32;

    typedef logic [MAX_PTR_WIDTH-1:0] wide_ptr_t;

    // Number of storage entries for the given address width.
    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // Occupancy = (wptr - rptr) mod 2**ptr_width. The wrap bit in the MSB is
    // what keeps full (difference DEPTH) distinct from empty (difference 0).
    // For ptr_width == 32 the shift yields zero and the mask becomes all ones.
    function automatic wide_ptr_t fifo_level(input wide_ptr_t   wptr,
                                             input wide_ptr_t   rptr,
                                             input int unsigned ptr_width);
        wide_ptr_t mask;
        mask = (wide_ptr_t'(1'b1) << ptr_width) - wide_ptr_t'(1'b1);
        return (wptr - rptr) & mask;
    endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog_if
// Handshake, data, control and status bundle of sync_fifo_prog.
//   master : producer/consumer side (drives requests, thresholds, flush, clr_err)
//   slave  : FIFO side (drives rdata, fill level and all status flags)
// -----------------------------------------------------------------------------
interface sync_fifo_prog_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    logic                  winc;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rinc;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  flush;
    logic                  clr_err;
    logic [ADDR_WIDTH:0]   afull_thr;
    logic [ADDR_WIDTH:0]   aempty_thr;
    logic                  wfull;
    logic                  rempty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output winc, wdata, rinc, flush, clr_err, afull_thr, aempty_thr,
        input  rdata, wfull, rempty, almost_full, almost_empty, level,
               overflow, underflow
    );

    modport slave (
        input  winc, wdata, rinc, flush, clr_err, afull_thr, aempty_thr,
        output rdata, wfull, rempty, almost_full, almost_empty, level,
               overflow, underflow
    );
endinterface

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// DEPTH x DATA_WIDTH storage array: synchronous write, asynchronous read.
// Contents are deliberately not reset; occupancy is tracked by the pointers.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : combinational read data at raddr
// -----------------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog
// Single-clock FIFO with standard or first-word-fall-through read mode,
// programmable almost-full/almost-empty thresholds, fill level, sticky
// overflow/underflow flags and a synchronous flush.
//   clk   : single clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset (empties the FIFO immediately)
//   bus   : slave side of sync_fifo_prog_if (winc/wdata/rinc/rdata, flush,
//           clr_err, thresholds, level and status flags)
// Status flags are combinational from the registered pointers and the
// threshold inputs, so they never lag the pointers by a cycle.
// -----------------------------------------------------------------------------
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int FWFT       = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sync_fifo_prog_if.slave        bus
);
    localparam int unsigned DEPTH     = fifo_depth(ADDR_WIDTH);
    localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;

    typedef logic [ADDR_WIDTH:0] ptr_t;
    typedef logic [ADDR_WIDTH:0] level_t;

    localparam ptr_t   PTR_ONE   = ptr_t'(1'b1);
    localparam level_t DEPTH_LVL = level_t'(DEPTH);
    localparam level_t LVL_ZERO  = level_t'(1'b0);

    ptr_t                  wptr_r;
    ptr_t                  rptr_r;
    level_t                level_s;
    logic                  wfull_s;
    logic                  rempty_s;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic                  ovf_set_s;
    logic                  unf_set_s;
    logic                  overflow_r;
    logic                  underflow_r;
    logic [DATA_WIDTH-1:0] mem_rdata_s;

    assign level_s  = level_t'(fifo_level(wide_ptr_t'(wptr_r), wide_ptr_t'(rptr_r), PTR_WIDTH));
    assign wfull_s  = (level_s == DEPTH_LVL);
    assign rempty_s = (level_s == LVL_ZERO);

    // Accept/reject decisions. Flush discards both requests without
    // counting them as errors; otherwise full/empty gate each side alone,
    // so winc&&rinc at full pops only and at empty pushes only.
    always_comb begin
        wr_acc_s  = 1'b0;
        rd_acc_s  = 1'b0;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        if (bus.flush) begin
            wr_acc_s  = 1'b0;
            rd_acc_s  = 1'b0;
            ovf_set_s = 1'b0;
            unf_set_s = 1'b0;
        end else begin
            wr_acc_s  = bus.winc && !wfull_s;
            rd_acc_s  = bus.rinc && !rempty_s;
            ovf_set_s = bus.winc && wfull_s;
            unf_set_s = bus.rinc && rempty_s;
        end
    end

    // Write pointer; the MSB toggles each time the index wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r <= '0;
        end else if (bus.flush) begin
            wptr_r <= '0;
        end else if (wr_acc_s) begin
            wptr_r <= wptr_r + PTR_ONE;
        end
    end

    // Read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_r <= '0;
        end else if (bus.flush) begin
            rptr_r <= '0;
        end else if (rd_acc_s) begin
            rptr_r <= rptr_r + PTR_ONE;
        end
    end

    // Sticky error flags: a new error in the same cycle beats clr_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_r <= 1'b0;
            end
            if (unf_set_s) begin
                underflow_r <= 1'b1;
            end else if (bus.clr_err) begin
                underflow_r <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc_s),
        .waddr (wptr_r[ADDR_WIDTH-1:0]),
        .wdata (bus.wdata),
        .raddr (rptr_r[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata_s)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word shown directly; forced to zero while empty so that reset
        // and flush present a defined value instead of stale storage.
        assign bus.rdata = rempty_s ? {DATA_WIDTH{1'b0}} : mem_rdata_s;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rdata_r;

        // Registered read data: loads the head word on an accepted read.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_r <= {DATA_WIDTH{1'b0}};
            end else if (bus.flush) begin
                rdata_r <= {DATA_WIDTH{1'b0}};
            end else if (rd_acc_s) begin
                rdata_r <= mem_rdata_s;
            end
        end

        assign bus.rdata = rdata_r;
    end

    assign bus.level        = level_s;
    assign bus.wfull        = wfull_s;
    assign bus.rempty       = rempty_s;
    // Thresholds above DEPTH can never be reached, so almost_full stays low.
    assign bus.almost_full  = (level_s >= bus.afull_thr);
    assign bus.almost_empty = (level_s <= bus.aempty_thr);
    assign bus.overflow     = overflow_r;
    assign bus.underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_prog
// Drives a standard-read and an FWFT instance with identical stimulus and
// compares both against a queue-based model every falling edge, plus literal
// expectations at the interesting points of each scenario.
// -----------------------------------------------------------------------------
module tb_sync_fifo_prog;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sync_fifo_prog_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_std ();
    sync_fifo_prog_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_fw ();

    sync_fifo_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) dut_std (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_std.slave)
    );

    sync_fifo_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) dut_fw (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_fw.slave)
    );

    // Behavioural model
    logic [7:0] q[$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;
    logic [7:0] m_rdata_std = 8'h00;
    int         thr_af = 14;
    int         thr_ae = 2;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic set_thr(input int af, input int ae);
        thr_af = af;
        thr_ae = ae;
        bus_std.afull_thr  = 5'(af);
        bus_fw.afull_thr   = 5'(af);
        bus_std.aempty_thr = 5'(ae);
        bus_fw.aempty_thr  = 5'(ae);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_rdata_std = 8'h00;
    endtask

    task automatic model_step(input logic w, input logic [7:0] wd, input logic r,
                              input logic fl, input logic ce);
        bit full;
        bit empty;
        bit sov;
        bit sun;
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        sov   = 1'b0;
        sun   = 1'b0;
        if (fl) begin
            q.delete();
            m_rdata_std = 8'h00;
        end else begin
            if (r && !empty) m_rdata_std = q.pop_front();
            if (w && !full) q.push_back(wd);
            sov = w && full;
            sun = r && empty;
        end
        m_ovf = sov ? 1'b1 : (ce ? 1'b0 : m_ovf);
        m_unf = sun ? 1'b1 : (ce ? 1'b0 : m_unf);
    endtask

    // One clock cycle of stimulus; returns 1 time unit after the rising edge.
    task automatic drive(input logic w, input logic [7:0] wd, input logic r,
                         input logic fl, input logic ce);
        bus_std.winc = w;  bus_fw.winc = w;
        bus_std.wdata = wd; bus_fw.wdata = wd;
        bus_std.rinc = r;  bus_fw.rinc = r;
        bus_std.flush = fl; bus_fw.flush = fl;
        bus_std.clr_err = ce; bus_fw.clr_err = ce;
        @(posedge clk);
        model_step(w, wd, r, fl, ce);
        #1;
        bus_std.winc = 1'b0; bus_fw.winc = 1'b0;
        bus_std.rinc = 1'b0; bus_fw.rinc = 1'b0;
        bus_std.flush = 1'b0; bus_fw.flush = 1'b0;
        bus_std.clr_err = 1'b0; bus_fw.clr_err = 1'b0;
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int         lvl;
        logic [7:0] head;
        if (chk_en) begin
            lvl  = q.size();
            head = (lvl > 0) ? q[0] : 8'h00;
            check("std_level",  32'(bus_std.level),        32'(lvl));
            check("fw_level",   32'(bus_fw.level),         32'(lvl));
            check("std_wfull",  32'(bus_std.wfull),        32'(lvl == DEPTH));
            check("fw_wfull",   32'(bus_fw.wfull),         32'(lvl == DEPTH));
            check("std_rempty", 32'(bus_std.rempty),       32'(lvl == 0));
            check("fw_rempty",  32'(bus_fw.rempty),        32'(lvl == 0));
            check("std_afull",  32'(bus_std.almost_full),  32'(lvl >= thr_af));
            check("fw_afull",   32'(bus_fw.almost_full),   32'(lvl >= thr_af));
            check("std_aempty", 32'(bus_std.almost_empty), 32'(lvl <= thr_ae));
            check("fw_aempty",  32'(bus_fw.almost_empty),  32'(lvl <= thr_ae));
            check("std_ovf",    32'(bus_std.overflow),     32'(m_ovf));
            check("fw_ovf",     32'(bus_fw.overflow),      32'(m_ovf));
            check("std_unf",    32'(bus_std.underflow),    32'(m_unf));
            check("fw_unf",     32'(bus_fw.underflow),     32'(m_unf));
            check("std_rdata",  32'(bus_std.rdata),        32'(m_rdata_std));
            check("fw_rdata",   32'(bus_fw.rdata),         32'(head));
        end
    end

    initial begin
        rst_n = 1'b0;
        bus_std.winc = 1'b0; bus_fw.winc = 1'b0;
        bus_std.wdata = 8'h00; bus_fw.wdata = 8'h00;
        bus_std.rinc = 1'b0; bus_fw.rinc = 1'b0;
        bus_std.flush = 1'b0; bus_fw.flush = 1'b0;
        bus_std.clr_err = 1'b0; bus_fw.clr_err = 1'b0;
        set_thr(14, 2);
        model_reset();
        chk_en = 1'b1;

        // Reset state
        #2;
        check("rst_level",  32'(bus_std.level), 32'd0);
        check("rst_rempty", 32'(bus_std.rempty), 32'd1);
        check("rst_wfull",  32'(bus_std.wfull), 32'd0);
        check("rst_aempty", 32'(bus_std.almost_empty), 32'd1);
        check("rst_afull",  32'(bus_std.almost_full), 32'd0);
        check("rst_rdata",  32'(bus_std.rdata), 32'd0);
        #10;
        rst_n = 1'b1;

        // Fill/drain
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            if (i == 12) check("afull_at13", 32'(bus_std.almost_full), 32'd0);
            if (i == 13) check("afull_at14", 32'(bus_std.almost_full), 32'd1);
        end
        check("fill_wfull", 32'(bus_std.wfull), 32'd1);
        check("fill_level", 32'(bus_std.level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            check("drain_rdata", 32'(bus_std.rdata), 32'(i));
        end
        check("drain_rempty", 32'(bus_std.rempty), 32'd1);
        check("drain_ovf", 32'(bus_std.overflow), 32'd0);

        // Overflow / underflow
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        check("ovf_set",   32'(bus_std.overflow), 32'd1);
        check("ovf_level", 32'(bus_std.level), 32'd16);
        for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("ovf_last_rdata", 32'(bus_std.rdata), 32'h2F);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("unf_set", 32'(bus_std.underflow), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("clr_ovf", 32'(bus_std.overflow), 32'd0);
        check("clr_unf", 32'(bus_std.underflow), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("set_beats_clr", 32'(bus_std.underflow), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Simultaneous read/write across pointer wrap
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 8'(8'h50 + k), 1'b1, 1'b0, 1'b0);
            check("sim_level", 32'(bus_std.level), 32'd5);
            check("sim_rdata", 32'(bus_std.rdata), (k < 5) ? 32'(8'h40 + k) : 32'(8'h50 + k - 5));
        end
        for (int i = 0; i < 5; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        check("full_both_level", 32'(bus_std.level), 32'd15);
        check("full_both_ovf",   32'(bus_std.overflow), 32'd1);
        check("full_both_rdata", 32'(bus_std.rdata), 32'h80);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        check("empty_both_level", 32'(bus_std.level), 32'd1);
        check("empty_both_unf",   32'(bus_std.underflow), 32'd1);
        check("empty_both_fw",    32'(bus_fw.rdata), 32'h99);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // FWFT fall-through
        drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        check("fwft_rdata",  32'(bus_fw.rdata), 32'h3C);
        check("fwft_rempty", 32'(bus_fw.rempty), 32'd0);
        drive(1'b1, 8'h3D, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("fwft_next", 32'(bus_fw.rdata), 32'h3D);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("fwft_empty", 32'(bus_fw.rempty), 32'd1);

        // Flush with concurrent requests
        for (int i = 0; i < 9; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        check("flush_level",  32'(bus_std.level), 32'd0);
        check("flush_rempty", 32'(bus_std.rempty), 32'd1);
        check("flush_ovf",    32'(bus_std.overflow), 32'd0);
        check("flush_unf",    32'(bus_std.underflow), 32'd0);
        check("flush_rdata",  32'(bus_std.rdata), 32'd0);
        drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        check("post_flush_fw", 32'(bus_fw.rdata), 32'h11);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("post_flush_std", 32'(bus_std.rdata), 32'h11);

        // Asynchronous reset between edges
        for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        check("pre_rst_level", 32'(bus_std.level), 32'd7);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_level",  32'(bus_std.level), 32'd0);
        check("arst_rempty", 32'(bus_std.rempty), 32'd1);
        check("arst_rdata",  32'(bus_std.rdata), 32'd0);
        check("arst_fw_rdata", 32'(bus_fw.rdata), 32'd0);
        #3;
        rst_n = 1'b1;

        // Threshold above DEPTH disables almost_full; low almost_empty edge
        set_thr(17, 0);
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        check("thr17_afull", 32'(bus_std.almost_full), 32'd0);
        set_thr(16, 15);
        #1;
        check("thr16_afull",  32'(bus_std.almost_full), 32'd1);
        check("thr15_aempty", 32'(bus_std.almost_empty), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("thr15_aempty_after", 32'(bus_std.almost_empty), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
